mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Multi-cycle sequencer for the load/store/fence controls decoded by the CPU control unit.
//  Accepts one memory op from execute, drives a 64-bit data bus with valid/ready request and rvalid response.
//  Stalls the pipeline for the duration of the op and returns extended load data.
//  Sits between the execute stage and the data-side bus/cache port.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles waited per bus phase before a timeout fault; 0 = no timeout
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  reset_n        in   1   asynchronous active-low reset
//  req_valid      in   1   op present from execute; held stable while stall_out=1
//  mem_read       in   1   load
//  mem_write      in   1   store (mem_read and mem_write are never both 1)
//  mem_fence      in   1   fence
//  mem_width      in   3   0=B 1=H 2=W 3=D, 4-7 illegal
//  mem_zero_ext   in   1   zero-extend load result (ignored for D)
//  addr           in   64  byte address
//  wdata          in   64  store data, LSBs significant
//  stall_out      out  1   = req_valid & (state!=DONE); combinational
//  done_out       out  1   one-cycle pulse, op retired
//  rdata_out      out  64  extended load data, valid with done_out
//  fault_out      out  1   with done_out: op faulted, no rd write
//  fault_cause    out  2   1=misaligned 2=bus error/timeout 3=illegal width
//  bus_valid      out  1   request valid
//  bus_ready      in   1   request accepted
//  bus_write      out  1   1=store 0=load
//  bus_addr       out  64  addr with [2:0] cleared
//  bus_wdata      out  64  wdata << 8*addr[2:0]
//  bus_wstrb      out  8   byte enables, (1<<size)-1 << addr[2:0]
//  bus_rvalid     in   1   response (load data or store ack)
//  bus_rdata      in   64  load data
//  bus_err        in   1   with bus_rvalid: access error
//  fence_req      out  1   drain request to memory system
//  fence_ack      in   1   drain complete
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (stall_out follows req_valid combinationally); timeout counter 0.
//  FSM: IDLE, ADDR, RESP, FENCE, DONE. Ops accepted only in IDLE.
//  IDLE: req_valid & (mem_read|mem_write): latch op; illegal width or misalign -> DONE with fault,
//    no bus activity; else -> ADDR. req_valid & mem_fence -> FENCE. req_valid, no op -> DONE (nop).
//  ADDR: bus_valid=1, bus fields stable; bus_ready -> RESP, counter cleared.
//  RESP: bus_rvalid -> DONE; bus_err -> fault cause 2. rvalid on the cycle after ready is legal.
//  FENCE: fence_req=1 until fence_ack (sampled same cycle) -> DONE.
//  DONE: done_out=1 (+ fault/rdata), stall_out=0, -> IDLE next cycle; minimum op latency 4 cycles
//    (IDLE,ADDR,RESP,DONE) with zero-wait bus.
//  Load data: bus_rdata >> 8*addr[2:0], truncated to size, sign-extended unless mem_zero_ext.
//  Timeout: counter increments in ADDR/RESP/FENCE, clears on state change; reaching
//    TIMEOUT_CYCLES-1 without handshake -> DONE with cause 2; bus_valid dropped. A late
//    bus_rvalid arriving outside RESP is ignored.
//  Misalign: addr[2:0] not a multiple of size.
//  Async reset mid-op: FSM to IDLE immediately, bus_valid/fence_req drop, op is lost.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: misaligned op -> fault cause 1, no bus access.
//  Undefined: addr low bits force-aligned to size (addr & ~(size-1)), op proceeds, no fault.
// TESTING
//  LW addr=0x1004, zero-wait bus, rdata=0x8000_0000_xxxx_xxxx -> bus_wstrb n/a,
//    done at cycle 4, rdata_out=0xFFFF_FFFF_8000_0000.
//  SB addr=0x1003 wdata=0xAB -> bus_wstrb=0x08, bus_wdata[31:24]=0xAB, bus_write=1.
//  LHU addr=0x1001 with _EN -> fault_out=1 cause=1, bus_valid never 1; without -> reads 0x1000.
//  bus_ready low 255 cycles, TIMEOUT_CYCLES=256 -> done_out+fault cause 2, bus_valid drops.
//  Fence with fence_ack after 5 cycles -> stall_out high 6 cycles, then done_out pulse.
//  reset_n low while in RESP -> bus_valid=0, done_out=0; next LD retires normally.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Data-side bus and fence handshake between the memory access sequencer
//   and the bus/cache port.
//   master modport: sequencer side (drives the request and the fence request)
//   slave  modport: memory side (drives ready, the response and the fence ack)
//   Signals:
//     bus_valid/bus_ready      request handshake
//     bus_write                1=store 0=load
//     bus_addr                 doubleword-aligned address
//     bus_wdata/bus_wstrb      lane-shifted store data and byte enables
//     bus_rvalid/bus_rdata     response (load data or store ack)
//     bus_err                  access error, qualified by bus_rvalid
//     fence_req/fence_ack      drain request / drain complete
interface mem_access_sequencer_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        bus_err;
    logic        fence_req;
    logic        fence_ack;

    modport master (
        output bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb, fence_req,
        input  bus_ready, bus_rvalid, bus_rdata, bus_err, fence_ack
    );

    modport slave (
        input  bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb, fence_req,
        output bus_ready, bus_rvalid, bus_rdata, bus_err, fence_ack
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle sequencer for load/store/fence ops from execute. Accepts one
//   op in IDLE, runs it on the 64-bit data bus (or the fence handshake),
//   stalls the pipeline meanwhile and retires it with a one-cycle done pulse
//   carrying extended load data or a fault cause.
//   Parameter: TIMEOUT_CYCLES - cycles waited per bus phase before a timeout
//     fault (0 disables the timeout).
//   Macro MEM_MISALIGN_TRAP_EN: when defined, misaligned ops fault with cause 1
//     and never reach the bus; when undefined, the address is force-aligned
//     to the access size and the op proceeds.
//   Ports:
//     clk, reset_n                core clock, async active-low reset
//     req_valid, mem_read/write/fence, mem_width, mem_zero_ext, addr, wdata
//                                 op from execute, stable while stall_out=1
//     stall_out                   req_valid & not retiring
//     done_out, rdata_out, fault_out, fault_cause
//                                 retirement pulse and its result
//     bus                         master side of mem_access_sequencer_if
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_fence,
    input  logic [2:0]  mem_width,
    input  logic        mem_zero_ext,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        stall_out,
    output logic        done_out,
    output logic [63:0] rdata_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause,
    mem_access_sequencer_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RESP, S_FENCE, S_DONE} state_t;

    // The counter holds cycles already spent in the current phase; the phase
    // is abandoned on the cycle that would bring it to TIMEOUT_CYCLES-1.
    localparam int unsigned WAIT_LIMIT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [31:0] cnt_q;

    logic        mem_op;
    logic        width_bad;
    logic        trap;
    logic [63:0] align_mask;
    logic [63:0] addr_eff;
    logic        timeout_hit;
    logic        resp_hs;
    logic        fence_hs;
    logic        in_wait;
    logic [63:0] rshift;
    logic [63:0] load_ext;
    logic [7:0]  strb_base;

    always_comb begin
        mem_op     = mem_read | mem_write;
        width_bad  = mem_width[2];
        align_mask = (64'd1 << mem_width[1:0]) - 64'd1;
`ifdef MEM_MISALIGN_TRAP_EN
        trap       = |(addr & align_mask);
        addr_eff   = addr;
`else
        trap       = 1'b0;
        addr_eff   = addr & ~align_mask;
`endif
        in_wait     = (state_q == S_ADDR) || (state_q == S_RESP) || (state_q == S_FENCE);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == WAIT_LIMIT);
        resp_hs     = (state_q == S_RESP) && bus.bus_rvalid;
        fence_hs    = (state_q == S_FENCE) && bus.fence_ack;
    end

    // Load lane extraction and extension
    always_comb begin
        rshift   = bus.bus_rdata >> {addr_q[2:0], 3'b000};
        load_ext = rshift;
        case (size_q)
            2'd0:    load_ext = zext_q ? {56'd0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
            2'd1:    load_ext = zext_q ? {48'd0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
            2'd2:    load_ext = zext_q ? {32'd0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (mem_op)         state_d = (width_bad || trap) ? S_DONE : S_ADDR;
                    else if (mem_fence) state_d = S_FENCE;
                    else                state_d = S_DONE;
                end
            end
            S_ADDR: begin
                if (bus.bus_ready)    state_d = S_RESP;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_RESP: begin
                if (bus.bus_rvalid || timeout_hit) state_d = S_DONE;
            end
            S_FENCE: begin
                if (bus.fence_ack || timeout_hit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 cnt_q <= '0;
        else if (state_d != state_q)  cnt_q <= '0;
        else if (in_wait)             cnt_q <= cnt_q + 32'd1;
        else                          cnt_q <= '0;
    end

    // Op latch and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cause_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (req_valid) begin
                write_q <= mem_write;
                size_q  <= mem_width[1:0];
                zext_q  <= mem_zero_ext;
                addr_q  <= addr_eff;
                wdata_q <= wdata;
                rdata_q <= '0;
                fault_q <= mem_op & (width_bad | trap);
                cause_q <= !mem_op  ? 2'd0 :
                           width_bad ? 2'd3 :
                           trap      ? 2'd1 : 2'd0;
            end
        end else if (in_wait && state_d == S_DONE) begin
            // Leaving a wait phase without its handshake can only be a timeout
            if (resp_hs) begin
                if (bus.bus_err) begin
                    fault_q <= 1'b1;
                    cause_q <= 2'd2;
                end else if (!write_q) begin
                    rdata_q <= load_ext;
                end
            end else if (!fence_hs) begin
                fault_q <= 1'b1;
                cause_q <= 2'd2;
            end
        end
    end

    // Outputs
    always_comb begin
        case (size_q)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase

        stall_out   = req_valid && (state_q != S_DONE);
        done_out    = (state_q == S_DONE);
        fault_out   = done_out & fault_q;
        fault_cause = done_out ? cause_q : 2'd0;
        rdata_out   = done_out ? rdata_q : '0;

        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_wstrb = '0;
        bus.fence_req = (state_q == S_FENCE);
        if (state_q == S_ADDR) begin
            bus.bus_valid = 1'b1;
            bus.bus_write = write_q;
            bus.bus_addr  = {addr_q[63:3], 3'b000};
            bus.bus_wdata = wdata_q << {addr_q[2:0], 3'b000};
            bus.bus_wstrb = strb_base << addr_q[2:0];
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;
    localparam int unsigned TO = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, mem_read, mem_write, mem_fence, mem_zero_ext;
    logic [2:0]  mem_width;
    logic [63:0] addr, wdata;
    logic        stall_out, done_out, fault_out;
    logic [63:0] rdata_out;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    mem_access_sequencer_if bus_if ();

    mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_fence    (mem_fence),
        .mem_width    (mem_width),
        .mem_zero_ext (mem_zero_ext),
        .addr         (addr),
        .wdata        (wdata),
        .stall_out    (stall_out),
        .done_out     (done_out),
        .rdata_out    (rdata_out),
        .fault_out    (fault_out),
        .fault_cause  (fault_cause),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: op kind 0=nop 1=load 2=store 3=fence
    task automatic model(input int kind, input logic [2:0] w, input logic z,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                         input logic er, input int unsigned rdly, input int unsigned vdly,
                         input int unsigned fdly,
                         output logic e_fault, output logic [1:0] e_cause,
                         output logic [63:0] e_rdata, output logic [63:0] e_baddr,
                         output logic [63:0] e_bwdata, output logic [7:0] e_strb,
                         output int unsigned e_lat, output int unsigned e_nvalid);
        longint unsigned nb, off, ea, v, lim;
        e_fault = 0; e_cause = 0; e_rdata = 0; e_baddr = 0; e_bwdata = 0;
        e_strb = 0; e_nvalid = 0; e_lat = 2;
        if (kind == 0) return;
        if (kind == 3) begin
            e_lat = fdly + 3;
            return;
        end
        if (w > 3) begin
            e_fault = 1; e_cause = 3;
            return;
        end
        nb = 64'd1 << w;
        ea = a;
        if (a % nb != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
            e_fault = 1; e_cause = 1;
            return;
`else
            ea = a - (a % nb);
`endif
        end
        off      = ea % 8;
        e_baddr  = ea - off;
        e_strb   = 8'(((64'd1 << nb) - 64'd1) << off);
        e_bwdata = wd << (8 * off);
        if (rdly >= TO - 1) begin
            e_fault = 1; e_cause = 2; e_lat = TO + 1; e_nvalid = TO - 1;
            return;
        end
        e_nvalid = rdly + 1;
        e_lat    = rdly + vdly + 4;
        if (er) begin
            e_fault = 1; e_cause = 2;
        end else if (kind == 1) begin
            v = rd >> (8 * off);
            if (nb < 8) begin
                lim = 64'd1 << (8 * nb);
                v = v % lim;
                if (!z && v >= lim / 2) v = v - lim;
            end
            e_rdata = v;
        end
    endtask

    // Called at a negedge with the DUT idle; returns two negedges after retirement.
    task automatic run_op(input int kind, input logic [2:0] w, input logic z,
                          input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                          input logic er, input int unsigned rdly, input int unsigned vdly,
                          input int unsigned fdly,
                          output logic [63:0] o_rdata, output int unsigned o_lat,
                          output logic [7:0] o_strb, output logic [63:0] o_wdata,
                          output logic [63:0] o_addr, output int unsigned o_nvalid);
        logic        e_fault;
        logic [1:0]  e_cause;
        logic [63:0] e_rdata, e_baddr, e_bwdata;
        logic [7:0]  e_strb;
        int unsigned e_lat, e_nvalid, acnt, vcnt, fcnt;
        logic        addr_ok, got_done;
        model(kind, w, z, a, wd, rd, er, rdly, vdly, fdly,
              e_fault, e_cause, e_rdata, e_baddr, e_bwdata, e_strb, e_lat, e_nvalid);
        o_rdata = 0; o_strb = 0; o_wdata = 0; o_addr = 0; o_nvalid = 0; o_lat = 1;
        acnt = 0; vcnt = 0; fcnt = 0; addr_ok = 0; got_done = 0;
        req_valid    = 1;
        mem_read     = (kind == 1);
        mem_write    = (kind == 2);
        mem_fence    = (kind == 3);
        mem_width    = w;
        mem_zero_ext = z;
        addr         = a;
        wdata        = wd;
        #1 check("stall_idle", stall_out, 1);
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(negedge clk);
            o_lat++;
            if (done_out) begin
                got_done = 1;
                bus_if.bus_ready = 0; bus_if.bus_rvalid = 0; bus_if.fence_ack = 0;
                check("stall_done", stall_out, 0);
                check("fault", fault_out, e_fault);
                check("cause", fault_cause, e_cause);
                check("rdata", rdata_out, e_rdata);
                check("latency", o_lat, e_lat);
                check("nvalid", o_nvalid, e_nvalid);
                check("bv_done", bus_if.bus_valid, 0);
                check("fr_done", bus_if.fence_req, 0);
                o_rdata = rdata_out;
                req_valid = 0; mem_read = 0; mem_write = 0; mem_fence = 0;
            end else begin
                check("stall_busy", stall_out, 1);
                if (bus_if.bus_valid) begin
                    if (o_nvalid == 0) begin
                        o_strb = bus_if.bus_wstrb; o_wdata = bus_if.bus_wdata; o_addr = bus_if.bus_addr;
                    end
                    o_nvalid++;
                    check("bus_addr", bus_if.bus_addr, e_baddr);
                    check("bus_write", bus_if.bus_write, (kind == 2));
                    if (kind == 2) begin
                        check("bus_wstrb", bus_if.bus_wstrb, e_strb);
                        check("bus_wdata", bus_if.bus_wdata, e_bwdata);
                    end
                    bus_if.bus_ready  = (acnt >= rdly);
                    acnt++;
                    if (bus_if.bus_ready) addr_ok = 1;
                    bus_if.bus_rvalid = 0;
                end else if (addr_ok) begin
                    bus_if.bus_ready  = 0;
                    bus_if.bus_rvalid = (vcnt >= vdly);
                    vcnt++;
                    bus_if.bus_rdata  = bus_if.bus_rvalid ? rd : {$urandom, $urandom};
                    bus_if.bus_err    = bus_if.bus_rvalid ? er : 1'b1;
                end
                if (bus_if.fence_req) begin
                    bus_if.fence_ack = (fcnt >= fdly);
                    fcnt++;
                end else begin
                    bus_if.fence_ack = 0;
                end
            end
        end
        if (!got_done) check("done_seen", 0, 1);
        @(negedge clk);
        check("done_pulse", done_out, 0);
        // Stray response while idle must be ignored
        bus_if.bus_rvalid = $urandom_range(0, 1);
        bus_if.bus_rdata  = {$urandom, $urandom};
        bus_if.bus_err    = $urandom_range(0, 1);
        @(negedge clk);
        check("idle_done", done_out, 0);
        bus_if.bus_rvalid = 0;
        bus_if.bus_err    = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, wd_o, ad_o;
        logic [7:0]  st;
        int unsigned lat, nv;
        int          kind;
        logic [2:0]  w;
        logic [63:0] a;

        reset_n = 0; req_valid = 0; mem_read = 0; mem_write = 0; mem_fence = 0;
        mem_width = 0; mem_zero_ext = 0; addr = 0; wdata = 0;
        bus_if.bus_ready = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
        bus_if.bus_err = 0; bus_if.fence_ack = 0;
        repeat (3) @(negedge clk);
        check("rst_done", done_out, 0);
        check("rst_stall", stall_out, 0);
        check("rst_fault", fault_out, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_bv", bus_if.bus_valid, 0);
        check("rst_fr", bus_if.fence_req, 0);
        reset_n = 1;
        @(negedge clk);

        // LW at 0x1004, zero-wait bus
        run_op(1, 3'd2, 0, 64'h1004, 64'h0, 64'h8000_0000_1234_5678, 0, 0, 0, 0, r, lat, st, wd_o, ad_o, nv);
        check("lw_rdata", r, 64'hFFFF_FFFF_8000_0000);
        check("lw_lat", lat, 4);

        // SB at 0x1003
        run_op(2, 3'd0, 0, 64'h1003, 64'hAB, 64'h0, 0, 1, 2, 0, r, lat, st, wd_o, ad_o, nv);
        check("sb_strb", st, 8'h08);
        check("sb_lane", wd_o[31:24], 8'hAB);

        // LHU at 0x1001
        run_op(1, 3'd1, 1, 64'h1001, 64'h0, 64'h1122_3344_5566_F788, 0, 0, 0, 0, r, lat, st, wd_o, ad_o, nv);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lhu_nobus", nv, 0);
`else
        check("lhu_addr", ad_o, 64'h1000);
        check("lhu_rdata", r, 64'hF788);
`endif

        // Illegal width
        run_op(2, 3'd5, 0, 64'h2000, 64'h55, 64'h0, 0, 0, 0, 0, r, lat, st, wd_o, ad_o, nv);
        check("bad_w_nobus", nv, 0);

        // Bus never ready -> timeout
        run_op(1, 3'd3, 0, 64'h3000, 64'h0, 64'h0, 0, 100000, 0, 0, r, lat, st, wd_o, ad_o, nv);
        check("to_nvalid", nv, TO - 1);

        // Fence, ack on the fifth fence_req cycle
        run_op(3, 3'd0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 4, r, lat, st, wd_o, ad_o, nv);
        check("fence_stall", lat - 1, 6);

        // Async reset while waiting for the response
        req_valid = 1; mem_read = 1; mem_width = 3'd3; addr = 64'h4000;
        bus_if.bus_ready = 1;
        @(negedge clk);
        check("rr_addr_phase", bus_if.bus_valid, 1);
        @(negedge clk);
        bus_if.bus_ready = 0;
        check("rr_resp_phase", bus_if.bus_valid, 0);
        reset_n = 0;
        #1;
        check("rr_bv", bus_if.bus_valid, 0);
        check("rr_done", done_out, 0);
        check("rr_fr", bus_if.fence_req, 0);
        req_valid = 0; mem_read = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run_op(1, 3'd3, 0, 64'h4008, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 1, 0, r, lat, st, wd_o, ad_o, nv);
        check("rr_ld", r, 64'hDEAD_BEEF_0BAD_F00D);

        // Randomized ops
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 4) ? 1 : (kind < 8) ? 2 : (kind == 8) ? 3 : 0;
            w = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << w[1:0]) - 1);
            run_op(kind, w, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), r, lat, st, wd_o, ad_o, nv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
